// File: rtl/pq_req_arb_if.sv
// Bus between pq_req_arb, its NREQ requesters and the shared priority queue.
// The arbiter uses the slave modport; the requester/queue side uses master.
interface pq_req_arb_if #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned KEY_WIDTH = 8,
    parameter int unsigned VAL_WIDTH = 8
);
    localparam int unsigned KVW = KEY_WIDTH + VAL_WIDTH;
    localparam int unsigned IDW = $clog2(NREQ);

    // requester side
    logic [NREQ-1:0]     req_enq;
    logic [NREQ-1:0]     req_deq;
    logic [NREQ*KVW-1:0] req_kv;
    logic [NREQ-1:0]     grant;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [KVW-1:0]      rsp_kv;

    // queue side
    logic                pq_enq;
    logic                pq_deq;
    logic [KVW-1:0]      pq_kv_in;
    logic [KVW-1:0]      pq_kv_out;
    logic                pq_busy;
    logic                pq_full;
    logic                pq_empty;

    logic                err;

    modport slave (
        input  req_enq, req_deq, req_kv, pq_kv_out, pq_busy, pq_full, pq_empty,
        output grant, rsp_valid, rsp_id, rsp_kv, pq_enq, pq_deq, pq_kv_in, err
    );

    modport master (
        output req_enq, req_deq, req_kv, pq_kv_out, pq_busy, pq_full, pq_empty,
        input  grant, rsp_valid, rsp_id, rsp_kv, pq_enq, pq_deq, pq_kv_in, err
    );
endinterface

// File: rtl/pq_req_arb.sv
// Round-robin arbiter serializing NREQ requesters' enqueue/dequeue commands onto one shared
// priority queue. Define PQ_ARB_TIMEOUT_EN to abort a WAIT after 255 busy cycles and raise sticky err.
module pq_req_arb #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned KEY_WIDTH = 8,
    parameter int unsigned VAL_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    pq_req_arb_if.slave bus
);
    localparam int unsigned    KVW     = KEY_WIDTH + VAL_WIDTH;
    localparam int unsigned    IDW     = $clog2(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  cur_id;
    logic            cur_enq;

    logic [NREQ-1:0] elig_enq_c;
    logic [NREQ-1:0] elig_deq_c;
    logic [KVW-1:0]  req_kv_c [NREQ];
    logic            sel_found_c;
    logic [IDW-1:0]  sel_id_c;
    logic            sel_enq_c;
    logic [KVW-1:0]  sel_kv_c;
    logic [IDW-1:0]  next_ptr_c;

`ifdef PQ_ARB_TIMEOUT_EN
    logic [7:0]      wait_cnt;
    logic            err_q;
`endif

    // Unpack the flat per-requester kv bus.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_kv_c[i] = bus.req_kv[i*KVW +: KVW];
        end
    end

    // First eligible requester at or after rr_ptr; enqueue beats dequeue for the same requester.
    always_comb begin
        logic [IDW-1:0] cand;
        elig_enq_c  = bus.req_enq & {NREQ{~bus.pq_full}};
        elig_deq_c  = bus.req_deq & {NREQ{~bus.pq_empty}};
        sel_found_c = 1'b0;
        sel_id_c    = '0;
        sel_enq_c   = 1'b0;
        sel_kv_c    = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(rr_ptr) + k) % NREQ);
            if (!sel_found_c && (elig_enq_c[cand] || elig_deq_c[cand])) begin
                sel_found_c = 1'b1;
                sel_id_c    = cand;
                sel_enq_c   = elig_enq_c[cand];
                sel_kv_c    = req_kv_c[cand];
            end
        end
    end

    always_comb begin
        next_ptr_c = (cur_id == LAST_ID) ? '0 : cur_id + IDW'(1);
    end

    // Command and response outputs are registered so they coincide with ISSUE and RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            cur_id        <= '0;
            cur_enq       <= 1'b0;
            bus.grant     <= '0;
            bus.pq_enq    <= 1'b0;
            bus.pq_deq    <= 1'b0;
            bus.pq_kv_in  <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_kv    <= '0;
`ifdef PQ_ARB_TIMEOUT_EN
            wait_cnt      <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            bus.grant     <= '0;
            bus.pq_enq    <= 1'b0;
            bus.pq_deq    <= 1'b0;
            bus.pq_kv_in  <= '0;
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_found_c) begin
                        cur_id       <= sel_id_c;
                        cur_enq      <= sel_enq_c;
                        bus.grant    <= NREQ'(1) << sel_id_c;
                        bus.pq_enq   <= sel_enq_c;
                        bus.pq_deq   <= ~sel_enq_c;
                        bus.pq_kv_in <= sel_enq_c ? sel_kv_c : '0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    rr_ptr   <= next_ptr_c;
`ifdef PQ_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state    <= WAIT;
                end
                WAIT: begin
                    if (!bus.pq_busy) begin
                        if (cur_enq) begin
                            state <= IDLE;
                        end else begin
                            bus.rsp_kv    <= bus.pq_kv_out;
                            bus.rsp_id    <= cur_id;
                            bus.rsp_valid <= 1'b1;
                            state         <= RESP;
                        end
                    end
`ifdef PQ_ARB_TIMEOUT_EN
                    else begin
                        // 255th busy cycle: give up on the queue without a response.
                        wait_cnt <= wait_cnt + 8'd1;
                        if (wait_cnt == 8'd254) begin
                            err_q <= 1'b1;
                            state <= IDLE;
                        end
                    end
`endif
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PQ_ARB_TIMEOUT_EN
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule
